// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the SS.cc BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned DIGIT_MAX_9 = 9;
  localparam int unsigned DIGIT_MAX_5 = 5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit that rolls over at MAX and reports a carry on that increment.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic at_max;

  assign at_max = (q == BCD_W'(MAX));
  assign carry  = inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: tick-enabled prescaler, debounced Start/Stop/Clear FSM and a
// four-digit BCD chain counting 00.00-59.99.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS = 10,
  parameter int unsigned PRESC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             btn_ss,
  input  logic             btn_clr,
  output logic [BCD_W-1:0] cs_ones,
  output logic [BCD_W-1:0] cs_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic             running,
  output logic             wrap_pulse
);

  logic         tick_q, tick_pulse;
  logic [1:0]   ss_sync_q, clr_sync_q;
  logic         ss_smp_q, clr_smp_q;
  logic         ss_evt, clr_evt;
  state_t       state_q, state_d;
  logic         running_d;
  logic [PRESC_W-1:0] presc_q;
  logic         count_en, presc_last, cs_inc;
  logic         carry_cs1, carry_cs10, carry_s1, carry_s10;

  assign tick_pulse = tick_in & ~tick_q;

  // Buttons are only looked at on ticks, so bounce inside one tick period is invisible.
  assign ss_evt  = tick_pulse & ss_sync_q[1] & ~ss_smp_q;
  assign clr_evt = tick_pulse & clr_sync_q[1] & ~clr_smp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      ss_smp_q   <= 1'b0;
      clr_smp_q  <= 1'b0;
    end else begin
      tick_q     <= tick_in;
      ss_sync_q  <= {ss_sync_q[0], btn_ss};
      clr_sync_q <= {clr_sync_q[0], btn_clr};
      if (tick_pulse) begin
        ss_smp_q  <= ss_sync_q[1];
        clr_smp_q <= clr_sync_q[1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_evt && !clr_evt) state_d = ST_RUN;
      ST_RUN:   if (clr_evt) state_d = ST_IDLE; else if (ss_evt) state_d = ST_PAUSE;
      ST_PAUSE: if (clr_evt) state_d = ST_IDLE; else if (ss_evt) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
  end

  // Counting uses the pre-edge state, so a stop still counts and a start does not.
  assign count_en   = (state_q == ST_RUN) & tick_pulse;
  assign presc_last = (presc_q == PRESC_W'(TICKS_PER_CS - 1));
  assign cs_inc     = count_en & presc_last & ~clr_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      running    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      running    <= running_d;
      wrap_pulse <= carry_s10 & ~clr_evt;
      if (clr_evt) begin
        presc_q <= '0;
      end else if (count_en) begin
        presc_q <= presc_last ? '0 : presc_q + 1'b1;
      end
    end
  end

  // Digits are already zero in IDLE, so clearing on every clear event is harmless.
  bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_evt),
    .inc   (cs_inc),
    .q     (cs_ones),
    .carry (carry_cs1)
  );

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_evt),
    .inc   (carry_cs1),
    .q     (cs_tens),
    .carry (carry_cs10)
  );

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_sec_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_evt),
    .inc   (carry_cs10),
    .q     (sec_ones),
    .carry (carry_s1)
  );

  bcd_digit #(.MAX(DIGIT_MAX_5)) u_sec_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_evt),
    .inc   (carry_s1),
    .q     (sec_tens),
    .carry (carry_s10)
  );

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with TICKS_PER_CS=2 and a clk/8 tick
// (clk/2 while fast-forwarding long runs).
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst, tick_in, btn_ss, btn_clr;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens;
  logic       running, wrap_pulse;
  logic [15:0] digits;

  int n_tests  = 0;
  int n_fail   = 0;
  int wrap_cnt = 0;

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic        run;
    int          wraps;
  } exp_t;

  typedef struct {
    string       name;
    int          ticks;
    int          half;
    logic        ss;
    logic        clr;
    logic [15:0] bcd;
    logic        run;
    int          wraps;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  stopwatch_core #(
    .TICKS_PER_CS (2),
    .PRESC_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .btn_ss     (btn_ss),
    .btn_clr    (btn_clr),
    .cs_ones    (cs_ones),
    .cs_tens    (cs_tens),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .running    (running),
    .wrap_pulse (wrap_pulse)
  );

  assign digits = {sec_tens, sec_ones, cs_tens, cs_ones};

  always #5 clk = ~clk;

  // Total number of clk cycles wrap_pulse has been seen high.
  always @(negedge clk) if (wrap_pulse === 1'b1) wrap_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic do_tick(input int half);
    tick_in = 1'b1;
    repeat (half) @(negedge clk);
    tick_in = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      check({e.name, "_digits"}, {16'h0, digits}, {16'h0, e.bcd});
      check({e.name, "_running"}, {31'h0, running}, {31'h0, e.run});
      check({e.name, "_wraps"}, wrap_cnt, e.wraps);
    end
  endtask

  // Set the buttons, let them through the synchronizer, then apply ticks and compare.
  task automatic apply(input string name, input int ticks, input int half, input logic ss,
                       input logic clr, input logic [15:0] bcd, input logic run,
                       input int wraps);
    exp_t e;
    btn_ss  = ss;
    btn_clr = clr;
    repeat (3) @(negedge clk);
    e.name  = name;
    e.bcd   = bcd;
    e.run   = run;
    e.wraps = wraps;
    sb.push_back(e);
    repeat (ticks) do_tick(half);
    #1;
    compare_pop();
  endtask

  initial begin
    vecs[0] = '{"start_held",   3,     4, 1'b1, 1'b0, 16'h0001, 1'b1, 0};
    vecs[1] = '{"held_more",    17,    4, 1'b1, 1'b0, 16'h0009, 1'b1, 0};
    vecs[2] = '{"to_01_00",     181,   4, 1'b0, 1'b0, 16'h0100, 1'b1, 0};
    vecs[3] = '{"to_03_44",     489,   1, 1'b0, 1'b0, 16'h0344, 1'b1, 0};
    vecs[4] = '{"stop_with_inc", 1,    4, 1'b1, 1'b0, 16'h0345, 1'b0, 0};
    vecs[5] = '{"pause_hold",   50,    4, 1'b0, 1'b0, 16'h0345, 1'b0, 0};
    vecs[6] = '{"resume_no_inc", 1,    4, 1'b1, 1'b0, 16'h0345, 1'b1, 0};
    vecs[7] = '{"resume_2t",    2,     4, 1'b0, 1'b0, 16'h0346, 1'b1, 0};
    vecs[8] = '{"to_59_99",     11306, 1, 1'b0, 1'b0, 16'h5999, 1'b1, 0};
    vecs[9] = '{"wrap",         2,     4, 1'b0, 1'b0, 16'h0000, 1'b1, 1};

    rst     = 1'b1;
    tick_in = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_digits", {16'h0, digits}, 32'h0);
    check("reset_running", {31'h0, running}, 32'h0);
    check("reset_wrap", {31'h0, wrap_pulse}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].name, vecs[i].ticks, vecs[i].half, vecs[i].ss, vecs[i].clr,
            vecs[i].bcd, vecs[i].run, vecs[i].wraps);
    end

    // Clear from PAUSE with a half-way prescaler, then prove the prescaler restarted at 0.
    apply("run_00_03",      6, 1, 1'b0, 1'b0, 16'h0003, 1'b1, 1);
    apply("stop_presc1",    1, 4, 1'b1, 1'b0, 16'h0003, 1'b0, 1);
    apply("clr_in_pause",   1, 4, 1'b0, 1'b1, 16'h0000, 1'b0, 1);
    apply("start_after_clr", 1, 4, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    apply("presc_zeroed",   1, 4, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
    apply("count_again",    2, 4, 1'b0, 1'b0, 16'h0001, 1'b1, 1);
    // ss and clr on the tick where an increment is due: clear wins.
    apply("ss_clr_same",    1, 4, 1'b1, 1'b1, 16'h0000, 1'b0, 1);
    apply("idle_no_count",  2, 4, 1'b0, 1'b0, 16'h0000, 1'b0, 1);

    // One-clk glitch between ticks is never sampled.
    btn_ss = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
    apply("glitch_ignored", 3, 4, 1'b0, 1'b0, 16'h0000, 1'b0, 1);

    // Asynchronous reset in the middle of a run and of a tick.
    apply("pre_rst_start",  1, 4, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    apply("pre_rst_run",    5, 4, 1'b0, 1'b0, 16'h0002, 1'b1, 1);
    tick_in = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_digits", {16'h0, digits}, 32'h0);
    check("async_rst_running", {31'h0, running}, 32'h0);
    check("async_rst_wrap", {31'h0, wrap_pulse}, 32'h0);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply("post_rst_idle",  2, 4, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    apply("post_rst_start", 1, 4, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    apply("post_rst_count", 2, 4, 1'b0, 1'b0, 16'h0001, 1'b1, 1);

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
